// File: rtl/cordic_pkg.sv
// Shared types and default widths for the CORDIC controller/datapath pair.
package cordic_pkg;
  localparam int CORDIC_BIT_WIDTH = 16;
  localparam int CORDIC_LOG2_BW   = 4;
  localparam int CORDIC_TAG_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, ROT, CAPT, RESULT} cordic_state_t;
endpackage

// File: rtl/cordic_ctrl.sv
// Sequencer for cordic_data: one request in, BIT_WIDTH rotation steps,
// capture of x/y, result held on a valid/ready output until consumed.
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH       = CORDIC_BIT_WIDTH,
  parameter int LOG_2_BIT_WIDTH = CORDIC_LOG2_BW,
  parameter int TAG_WIDTH       = CORDIC_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_target,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 dp_load_regs,
  output logic                 dp_add,
  output logic                 dp_sub,
  output logic                 dp_iter,
  output logic [BIT_WIDTH-1:0] dp_target,
  input  logic                 dp_dir,
  input  logic                 dp_reached,
  input  logic [BIT_WIDTH-1:0] dp_x,
  input  logic [BIT_WIDTH-1:0] dp_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_x,
  output logic [BIT_WIDTH-1:0] out_y,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy,
  output logic                 err
);

  cordic_state_t              state;
  logic [LOG_2_BIT_WIDTH-1:0] cnt;
  logic [TAG_WIDTH-1:0]       tag_q;
  logic                       last;

  assign last = (state == ROT) && (cnt == LOG_2_BIT_WIDTH'(BIT_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tag_q     <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_tag   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          tag_q <= in_tag;
          cnt   <= '0;
          state <= ROT;
        end
        ROT: begin
          // datapath's own terminal flag must agree with our step count
          if (dp_reached != last) err <= 1'b1;
          if (last) begin
            cnt   <= '0;
            state <= CAPT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPT: begin
          out_x     <= dp_x;
          out_y     <= dp_y;
          out_tag   <= tag_q;
          out_valid <= 1'b1;
          state     <= RESULT;
        end
        RESULT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready     = 1'b0;
    dp_load_regs = 1'b0;
    dp_target    = '0;
    dp_add       = 1'b0;
    dp_sub       = 1'b0;
    dp_iter      = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready     = 1'b1;
        dp_load_regs = in_valid;
        dp_target    = in_target;
      end
      ROT: begin
        dp_add  = dp_dir;
        dp_sub  = !dp_dir;
        dp_iter = !last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cordic_ctrl.sv
// Randomized bench for cordic_ctrl; the bench plays the datapath and predicts
// every control/result cycle from the request-level timing rules.
module tb_cordic_ctrl;
  localparam int BW = 16;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [BW-1:0] in_target;
  logic [TW-1:0] in_tag;
  logic          dp_load_regs, dp_add, dp_sub, dp_iter;
  logic [BW-1:0] dp_target;
  logic          dp_dir, dp_reached;
  logic [BW-1:0] dp_x, dp_y;
  logic          out_valid, out_ready;
  logic [BW-1:0] out_x, out_y;
  logic [TW-1:0] out_tag;
  logic          busy, err;

  int vec_cnt  = 0;
  int miscmp   = 0;
  bit err_exp  = 1'b0;

  always #5 clk = ~clk;

  cordic_ctrl #(.BIT_WIDTH(BW), .LOG_2_BIT_WIDTH(4), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_target(in_target), .in_tag(in_tag),
    .dp_load_regs(dp_load_regs), .dp_add(dp_add), .dp_sub(dp_sub), .dp_iter(dp_iter),
    .dp_target(dp_target), .dp_dir(dp_dir), .dp_reached(dp_reached),
    .dp_x(dp_x), .dp_y(dp_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_tag(out_tag), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // accept cycle, BW rotation cycles, capture cycle, hold cycles, drain cycle
  task automatic run(input logic [TW-1:0] tg, input logic [BW-1:0] tgt, input int dmode,
                     input int hold, input int fault_at, input int abort_at,
                     input bit chain);
    logic [BW-1:0] rx, ry;
    in_valid = 1'b1; in_target = tgt; in_tag = tg;
    #1;
    chk("acc_ready", in_ready, 1); chk("acc_load", dp_load_regs, 1);
    chk("acc_target", dp_target, tgt); chk("acc_busy", busy, 0);
    chk("acc_ovalid", out_valid, 0); chk("acc_err", err, err_exp);
    @(negedge clk);
    in_valid = 1'b0; in_target = $urandom;
    for (int k = 0; k < BW; k++) begin
      dp_dir     = (dmode == 1) ? 1'b1 : (dmode == 2) ? 1'b0 : 1'($urandom);
      dp_reached = (k == BW-1) || (k == fault_at);
      dp_x = $urandom; dp_y = $urandom;
      if (k == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; err_exp = 1'b0;
        #1;
        chk("rst_load", dp_load_regs, 0); chk("rst_add", dp_add, 0);
        chk("rst_sub", dp_sub, 0); chk("rst_iter", dp_iter, 0);
        chk("rst_ovalid", out_valid, 0); chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0); chk("rst_err", err, 0);
        @(negedge clk);
        return;
      end
      #1;
      chk("rot_add", dp_add, dp_dir); chk("rot_sub", dp_sub, !dp_dir);
      chk("rot_iter", dp_iter, k != BW-1); chk("rot_load", dp_load_regs, 0);
      chk("rot_busy", busy, 1); chk("rot_ready", in_ready, 0);
      chk("rot_ovalid", out_valid, 0); chk("rot_err", err, err_exp);
      if (dp_reached != (k == BW-1)) err_exp = 1'b1;
      @(negedge clk);
    end
    rx = $urandom; ry = $urandom;
    dp_x = rx; dp_y = ry; dp_dir = $urandom; dp_reached = 1'b0;
    #1;
    chk("capt_ctl", {dp_load_regs, dp_add, dp_sub, dp_iter}, 0);
    chk("capt_ovalid", out_valid, 0); chk("capt_busy", busy, 1);
    chk("capt_err", err, err_exp);
    @(negedge clk);
    for (int h = 0; h <= hold; h++) begin
      out_ready = (h == hold);
      in_valid  = (h == hold) && chain;
      dp_x = $urandom; dp_y = $urandom;
      #1;
      chk("res_ovalid", out_valid, 1); chk("res_x", out_x, rx);
      chk("res_y", out_y, ry); chk("res_tag", out_tag, tg);
      chk("res_ready", in_ready, 0); chk("res_busy", busy, 1);
      chk("res_load", dp_load_regs, 0); chk("res_err", err, err_exp);
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_target = '0; in_tag = '0;
    dp_dir = 1'b0; dp_reached = 1'b0; dp_x = '0; dp_y = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ovalid", out_valid, 0); chk("reset_ox", out_x, 0);
    chk("reset_oy", out_y, 0); chk("reset_otag", out_tag, 0);
    chk("reset_err", err, 0); chk("reset_busy", busy, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_ctl", {dp_load_regs, dp_add, dp_sub, dp_iter}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(4'h5, '0, 0, 0, -1, -1, 0);          // basic, target 0
    run(4'hA, 16'h1234, 0, 5, -1, -1, 0);    // stalled consumer
    run(4'h3, 16'h0F0F, 0, 0, -1, 7, 0);     // reset in ROT step 7
    run(4'h9, 16'h2222, 0, 0, -1, -1, 1);    // new request waiting on drain
    run(4'h6, 16'h4444, 0, 2, -1, -1, 0);
    run(4'hC, 16'h1111, 1, 0, -1, -1, 0);    // dir forced high
    run(4'hD, 16'h7777, 2, 0, -1, -1, 0);    // dir forced low
    run(4'h1, 16'h0001, 0, 1, 5, -1, 0);     // early reached -> sticky err
    run(4'h2, 16'h0002, 0, 0, -1, -1, 0);    // err must persist
    rst_n = 1'b0; err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("err_cleared", err, 0);
    @(negedge clk);

    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 3)) begin
        #1;
        chk("idle_ready", in_ready, 1); chk("idle_busy", busy, 0);
        chk("idle_ovalid", out_valid, 0); chk("idle_load", dp_load_regs, 0);
        @(negedge clk);
      end
      run(TW'($urandom), BW'($urandom), $urandom_range(0, 2), $urandom_range(0, 4),
          ($urandom_range(0, 7) == 0) ? $urandom_range(0, BW-2) : -1,
          ($urandom_range(0, 9) == 0) ? $urandom_range(0, BW-1) : -1,
          1'($urandom));
    end
    #1;
    chk("final_ovalid", out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

  // add and sub are exclusive on every clock regardless of stimulus
  always @(negedge clk) begin
    #2;
    if (dp_add && dp_sub) begin
      miscmp++;
      $display("FAIL add_sub_excl: got add=%0b sub=%0b expected not both", dp_add, dp_sub);
    end
  end
endmodule
